// File: rtl/and_or_tri_pkg.sv
// Shared types, default sizes and small index helpers for the AND-OR tri-state bus driver.
package and_or_tri_pkg;

    // Bus ownership phases
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH       = 4;
    localparam int unsigned DEF_NCH         = 4;
    localparam int unsigned DEF_MAX_HOLD    = 8;
    localparam int unsigned DEF_TURN_CYCLES = 1;
    localparam int unsigned MAX_NCH         = 32;

    // Bits needed to hold 0..n-1 (never less than one bit)
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index to one-hot, caller narrows to its channel count
    function automatic logic [MAX_NCH-1:0] idx_to_onehot(input int unsigned idx);
        logic [MAX_NCH-1:0] oh;
        oh = MAX_NCH'(1) << idx;
        return oh;
    endfunction

    // Round-robin successor of idx among n channels
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter
    import and_or_tri_pkg::*;
#(
    parameter  int unsigned NCH   = DEF_NCH,
    localparam int unsigned IDX_W = idx_width(NCH)
) (
    input  logic [NCH-1:0]   req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NCH-1:0]   win,
    output logic [IDX_W-1:0] win_idx,
    output logic             any
);

    logic [NCH-1:0]   rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;

    // Rotate so ptr sits at bit 0, find the lowest set bit, then rotate the index back
    always_comb begin
        rot = NCH'({req, req} >> ptr);
        off = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IDX_W+1)'(NCH)) sum = sum - (IDX_W+1)'(NCH);
        win_idx = sum[IDX_W-1:0];
        any     = |req;
        win     = any ? NCH'(idx_to_onehot(32'(win_idx))) : '0;
    end

endmodule

// File: rtl/and_or_tri_bus.sv
// Registered AND-OR tri-state bus driver shared by NCH round-robin arbitrated channels,
// with guaranteed high-Z turnaround between owners.
module and_or_tri_bus
    import and_or_tri_pkg::*;
#(
    parameter  int unsigned WIDTH       = DEF_WIDTH,
    parameter  int unsigned NCH         = DEF_NCH,
    parameter  int unsigned MAX_HOLD    = DEF_MAX_HOLD,
    parameter  int unsigned TURN_CYCLES = DEF_TURN_CYCLES,
    localparam int unsigned IDX_W       = idx_width(NCH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH-1:0]     req,
    input  logic [NCH*WIDTH-1:0] a,
    input  logic [NCH*WIDTH-1:0] b,
    input  logic [NCH*WIDTH-1:0] c,
    input  logic [NCH*WIDTH-1:0] d,
    output logic [NCH-1:0]     gnt,
    output logic [IDX_W-1:0]   owner,
    output logic               f_oe,
    output wire  [WIDTH-1:0]   f
);

    localparam int unsigned HOLD_W = idx_width((MAX_HOLD == 0) ? 2 : MAX_HOLD);
    localparam int unsigned TURN_W = idx_width(TURN_CYCLES);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   f_q, f_q_d;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;
    logic [HOLD_W-1:0]  hold_cnt, hold_cnt_d;
    logic [TURN_W-1:0]  turn_cnt, turn_cnt_d;
    logic [NCH-1:0]     gnt_d;
    logic [IDX_W-1:0]   owner_d;
    logic               f_oe_d;

    logic [NCH-1:0]     arb_win;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               hold_last_c;
    logic               turn_last_c;
    logic               drive_exit_c;
    logic [WIDTH-1:0]   lane_f [NCH];

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req     (req),
        .ptr     (rr_ptr),
        .win     (arb_win),
        .win_idx (arb_idx),
        .any     (arb_any)
    );

    // Per-channel AND-OR terms
    for (genvar k = 0; k < NCH; k++) begin : g_lane
        assign lane_f[k] = (a[k*WIDTH +: WIDTH] & b[k*WIDTH +: WIDTH])
                         | (c[k*WIDTH +: WIDTH] & d[k*WIDTH +: WIDTH]);
    end

    assign hold_last_c  = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign turn_last_c  = (turn_cnt == TURN_W'(TURN_CYCLES - 1));
    assign drive_exit_c = !req[owner] || hold_last_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (arb_any) state_d = ST_DRIVE;
            ST_DRIVE: if (drive_exit_c) state_d = ST_TURN;
            ST_TURN:  if (turn_last_c) state_d = arb_any ? ST_DRIVE : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and counters
    always_comb begin
        gnt_d      = gnt;
        f_oe_d     = f_oe;
        owner_d    = owner;
        f_q_d      = f_q;
        rr_ptr_d   = rr_ptr;
        hold_cnt_d = hold_cnt;
        turn_cnt_d = turn_cnt;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    gnt_d      = arb_win;
                    f_oe_d     = 1'b1;
                    owner_d    = arb_idx;
                    f_q_d      = lane_f[arb_idx];
                    hold_cnt_d = '0;
                end
            end
            ST_DRIVE: begin
                f_q_d = lane_f[owner];
                if (drive_exit_c) begin
                    gnt_d      = '0;
                    f_oe_d     = 1'b0;
                    rr_ptr_d   = IDX_W'(next_idx(32'(owner), NCH));
                    turn_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt + 1'b1;
                end
            end
            ST_TURN: begin
                if (!turn_last_c) begin
                    turn_cnt_d = turn_cnt + 1'b1;
                end else if (arb_any) begin
                    gnt_d      = arb_win;
                    f_oe_d     = 1'b1;
                    owner_d    = arb_idx;
                    f_q_d      = lane_f[arb_idx];
                    hold_cnt_d = '0;
                end
            end
            default: begin
                gnt_d  = '0;
                f_oe_d = 1'b0;
            end
        endcase
    end

    // Output, data and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt      <= '0;
            f_oe     <= 1'b0;
            owner    <= '0;
            f_q      <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            turn_cnt <= '0;
        end else begin
            gnt      <= gnt_d;
            f_oe     <= f_oe_d;
            owner    <= owner_d;
            f_q      <= f_q_d;
            rr_ptr   <= rr_ptr_d;
            hold_cnt <= hold_cnt_d;
            turn_cnt <= turn_cnt_d;
        end
    end

    // Tri-state pad driver
    assign f = f_oe ? f_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_and_or_tri_bus.sv
// Self-checking bench for and_or_tri_bus: directed sequences, an operand table and
// randomized traffic against a transaction-level ownership model.
module tb_and_or_tri_bus;

    localparam int unsigned W  = 4;
    localparam int unsigned N  = 4;
    localparam int          MH = 8;
    localparam int          TC = 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_m, req_nh, req_t3;
    logic [N*W-1:0] a, b, c, d;
    logic [N-1:0]   gnt_m, gnt_nh, gnt_t3;
    logic [1:0]     own_m, own_nh, own_t3;
    logic           oe_m, oe_nh, oe_t3;
    wire  [W-1:0]   f_m, f_nh, f_t3;

    int nchk;
    int nerr;

    always #5 clk = ~clk;

    and_or_tri_bus #(.WIDTH(4), .NCH(4), .MAX_HOLD(8), .TURN_CYCLES(1)) u_main (
        .clk(clk), .rst_n(rst_n), .req(req_m), .a(a), .b(b), .c(c), .d(d),
        .gnt(gnt_m), .owner(own_m), .f_oe(oe_m), .f(f_m));

    and_or_tri_bus #(.WIDTH(4), .NCH(4), .MAX_HOLD(0), .TURN_CYCLES(1)) u_nohold (
        .clk(clk), .rst_n(rst_n), .req(req_nh), .a(a), .b(b), .c(c), .d(d),
        .gnt(gnt_nh), .owner(own_nh), .f_oe(oe_nh), .f(f_nh));

    and_or_tri_bus #(.WIDTH(4), .NCH(4), .MAX_HOLD(8), .TURN_CYCLES(3)) u_turn3 (
        .clk(clk), .rst_n(rst_n), .req(req_t3), .a(a), .b(b), .c(c), .d(d),
        .gnt(gnt_t3), .owner(own_t3), .f_oe(oe_t3), .f(f_t3));

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Grant sanity on every instance
    task automatic mon(input string name, input logic [N-1:0] g, input logic oe);
        nchk++;
        if (!$onehot0(g) || (oe && !$onehot(g))) begin
            nerr++;
            $display("FAIL %s_onehot: gnt %b f_oe %b at %0t", name, g, oe, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon("main", gnt_m, oe_m);
            mon("nohold", gnt_nh, oe_nh);
            mon("turn3", gnt_t3, oe_t3);
        end
    end

    // Ownership model of u_main: who holds the bus, how long, how much turnaround remains
    int          m_cur;
    int          m_used;
    int          m_turn;
    int          m_ptr;
    int          m_last;
    logic [W-1:0] m_f;

    function automatic logic [W-1:0] ref_andor(input int k);
        return (a[k*W +: W] & b[k*W +: W]) | (c[k*W +: W] & d[k*W +: W]);
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < int'(N); i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic model_reset;
        m_cur  = -1;
        m_used = 0;
        m_turn = 0;
        m_ptr  = 0;
        m_last = 0;
        m_f    = '0;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        int w;
        bit may_start;
        if (m_cur >= 0) begin
            m_used++;
            if (!r[m_cur] || (MH != 0 && m_used == MH)) begin
                m_ptr  = (m_cur + 1) % N;
                m_cur  = -1;
                m_turn = TC;
            end else begin
                m_f = ref_andor(m_cur);
            end
        end else begin
            may_start = 1'b1;
            if (m_turn > 0) begin
                m_turn--;
                may_start = (m_turn == 0);
            end
            if (may_start) begin
                w = pick(r, m_ptr);
                if (w >= 0) begin
                    m_cur  = w;
                    m_used = 0;
                    m_last = w;
                    m_f    = ref_andor(w);
                end
            end
        end
    endtask

    // One clock: advance the model, clock the DUTs, compare u_main against the model
    task automatic tick;
        model_step(req_m);
        @(posedge clk);
        #1;
        chk("m_gnt", gnt_m, (m_cur >= 0) ? (1 << m_cur) : 0);
        chk("m_oe", oe_m, (m_cur >= 0) ? 1 : 0);
        chk("m_owner", own_m, m_last);
        if (m_cur >= 0) chk("m_f", f_m, m_f);
    endtask

    task automatic do_reset;
        #2;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] vc;
        logic [W-1:0] vd;
        logic [W-1:0] exp_f;
    } vec_t;

    vec_t tbl [8];
    int   rr_seq [5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'hF, 4'h3, 4'h0, 4'h0, 4'h3};
        tbl[1] = '{4'hF, 4'h3, 4'hC, 4'hF, 4'hF};
        tbl[2] = '{4'hA, 4'h5, 4'h0, 4'h0, 4'h0};
        tbl[3] = '{4'hA, 4'hF, 4'h5, 4'h5, 4'hF};
        tbl[4] = '{4'hC, 4'h6, 4'h3, 4'h1, 4'h5};
        tbl[5] = '{4'h0, 4'hF, 4'hF, 4'h0, 4'h0};
        tbl[6] = '{4'h9, 4'hB, 4'h6, 4'hE, 4'hF};
        tbl[7] = '{4'h8, 4'h8, 4'h1, 4'h3, 4'h9};
        rr_seq = '{0, 1, 2, 3, 0};

        nchk   = 0;
        nerr   = 0;
        rst_n  = 1'b0;
        req_m  = '0;
        req_nh = '0;
        req_t3 = '0;
        a = '0; b = '0; c = '0; d = '0;
        model_reset();

        // Reset state
        #12;
        chk("rst_gnt", gnt_m, 0);
        chk("rst_oe", oe_m, 0);
        chk("rst_owner", own_m, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester, one-clock latency, then operand change
        a[W-1:0] = 4'hF; b[W-1:0] = 4'h3; c[W-1:0] = 4'h0; d[W-1:0] = 4'h0;
        req_m = 4'b0001;
        tick();
        chk("t2_gnt", gnt_m, 4'b0001);
        chk("t2_oe", oe_m, 1);
        chk("t2_f", f_m, 4'h3);
        c[W-1:0] = 4'hC; d[W-1:0] = 4'hF;
        tick();
        chk("t2_f_upd", f_m, 4'hF);
        tick();

        // Asynchronous reset in the middle of a drive
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_gnt", gnt_m, 0);
        chk("t1_oe", oe_m, 0);
        chk("t1_owner", own_m, 0);
        model_reset();
        req_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            chk("t1_idle_oe", oe_m, 0);
        end

        // Full rotation with hold limit and single turnaround cycles
        do_reset();
        req_m = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            repeat (8) begin
                tick();
                chk("t3_gnt", gnt_m, 1 << rr_seq[k]);
            end
            if (k < 4) begin
                tick();
                chk("t3_turn_gnt", gnt_m, 0);
                chk("t3_turn_oe", oe_m, 0);
            end
        end

        // Owner drops early, re-requests during turnaround, loses to ch3
        do_reset();
        req_m = 4'b0100;
        repeat (3) begin
            tick();
            chk("t4_gnt2", gnt_m, 4'b0100);
        end
        req_m = 4'b1000;
        tick();
        chk("t4_turn_oe", oe_m, 0);
        req_m = 4'b1100;
        tick();
        chk("t4_gnt3", gnt_m, 4'b1000);
        chk("t4_owner", own_m, 3);
        req_m = '0;
        tick();
        tick();

        // Unlimited hold: continuous grant, then one turnaround and idle
        do_reset();
        req_nh = 4'b0100;
        repeat (50) begin
            tick();
            chk("t5_gnt", gnt_nh, 4'b0100);
            chk("t5_oe", oe_nh, 1);
        end
        req_nh = '0;
        tick();
        chk("t5_turn_oe", oe_nh, 0);
        chk("t5_turn_gnt", gnt_nh, 0);
        tick();
        chk("t5_idle_oe", oe_nh, 0);
        chk("t5_owner", own_nh, 2);

        // Operand table on ch0 with unlimited hold
        do_reset();
        a = '0; b = '0; c = '0; d = '0;
        req_nh = 4'b0001;
        tick();
        for (int i = 0; i < 8; i++) begin
            a[W-1:0] = tbl[i].va;
            b[W-1:0] = tbl[i].vb;
            c[W-1:0] = tbl[i].vc;
            d[W-1:0] = tbl[i].vd;
            tick();
            chk("tbl_f", f_nh, tbl[i].exp_f);
            chk("tbl_gnt", gnt_nh, 4'b0001);
        end
        req_nh = '0;

        // Three-cycle turnaround between ch1 and ch2
        do_reset();
        req_t3 = 4'b0010;
        tick();
        chk("t6_gnt1", gnt_t3, 4'b0010);
        tick();
        req_t3 = 4'b0100;
        repeat (3) begin
            tick();
            chk("t6_turn_oe", oe_t3, 0);
            chk("t6_turn_gnt", gnt_t3, 0);
        end
        tick();
        chk("t6_gnt2", gnt_t3, 4'b0100);
        chk("t6_oe", oe_t3, 1);
        chk("t6_f", f_t3, ref_andor(2));
        req_t3 = '0;

        // Randomized traffic on u_main against the model
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            c = 16'($urandom);
            d = 16'($urandom);
            for (int i = 0; i < int'(N); i++) begin
                if ($urandom_range(9) == 0) req_m[i] = ~req_m[i];
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
